// File: rtl/lpc_uart_pkg.sv
// ============================================================================
// Module   : lpc_uart_pkg
// Brief    : Shared FSM states, LPC cycle codes, register offsets, LSR bits
// Revision : 1.0
// ============================================================================
`default_nettype none

package lpc_uart_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_CTDIR    = 4'd1,
        ST_ADDR3    = 4'd2,
        ST_ADDR2    = 4'd3,
        ST_ADDR1    = 4'd4,
        ST_ADDR0    = 4'd5,
        ST_WDATA_LO = 4'd6,
        ST_WDATA_HI = 4'd7,
        ST_HTAR0    = 4'd8,
        ST_HTAR1    = 4'd9,
        ST_SYNC     = 4'd10,
        ST_RDATA_LO = 4'd11,
        ST_RDATA_HI = 4'd12,
        ST_PTAR0    = 4'd13,
        ST_PTAR1    = 4'd14
    } lpc_state_e;

    localparam logic [3:0] c_START       = 4'b0000;
    localparam logic [3:0] c_CTDIR_IO_RD = 4'b0000;
    localparam logic [3:0] c_CTDIR_IO_WR = 4'b0010;
    localparam logic [3:0] c_SYNC_READY  = 4'b0000;
    localparam logic [3:0] c_SYNC_LWAIT  = 4'b0110;
    localparam logic [3:0] c_TAR_DRIVE   = 4'b1111;

    localparam logic [2:0] c_REG_DATA = 3'd0;
    localparam logic [2:0] c_REG_LSR  = 3'd5;
    localparam logic [2:0] c_REG_SCR  = 3'd7;

    localparam int c_LSR_RX_AVAIL = 0;
    localparam int c_LSR_RX_OVR   = 1;
    localparam int c_LSR_TX_OVF   = 2;
    localparam int c_LSR_TX_NFULL = 5;
    localparam int c_LSR_TX_IDLE  = 6;

endpackage

`default_nettype wire

// File: rtl/lpc_uart_fifo.sv
// ============================================================================
// Module   : lpc_uart_fifo
// Brief    : Synchronous FIFO with wrap-bit pointers; push on full accepted
//            only when a pop happens in the same cycle
// Revision : 1.0
// ============================================================================
`default_nettype none

module lpc_uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_empty,
    output logic             o_full
);

    localparam int c_AW = $clog2(DEPTH);

    logic [c_AW:0]      r_wptr;
    logic [c_AW:0]      r_rptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_do_push;
    logic               w_do_pop;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                       (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    // Head reads as zero when empty so downstream never sees stale storage
    assign o_head    = o_empty ? '0 : r_mem[r_rptr[c_AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr[c_AW-1:0]] <= i_push_data;
    end

endmodule

`default_nettype wire

// File: rtl/lpc_uart_target.sv
// ============================================================================
// Module   : lpc_uart_target
// Brief    : LPC I/O target with 16550-style byte window, RX/TX FIFOs.
//            Define LPC_UART_LONG_WAIT_EN for long-wait SYNC on TX full.
// Revision : 1.0
// ============================================================================
`default_nettype none

module lpc_uart_target
    import lpc_uart_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'h03F8,
    parameter int          RX_DEPTH  = 4,
    parameter int          TX_DEPTH  = 4
) (
    input  logic       lpc_clk,
    input  logic       lpc_rst,
    input  logic       lpc_frame,
    inout  wire  [3:0] lpc_data,
    output logic [7:0] tx_data,
    output logic       tx_data_valid,
    input  logic       tx_ready,
    input  logic       tx_busy,
    input  logic [7:0] rx_data,
    input  logic       rx_data_valid
);

    lpc_state_e r_state;
    lpc_state_e w_state_nx;
    logic       r_is_write;
    logic [11:0] r_addr;
    logic [7:0] r_wdata;
    logic [7:0] r_rdata;
    logic       r_rd_pop;
    logic       r_lad_oe;
    logic [3:0] r_lad_out;
    logic       r_wait;
    logic [7:0] r_scratch;
    logic       r_rx_overrun;
    logic       r_tx_overflow;

    logic       w_lad_oe_nx;
    logic [3:0] w_lad_out_nx;
    logic       w_wait_nx;
    logic       w_tx_push;
    logic       w_tx_ovf_set;
    logic       w_scr_we;
    logic       w_rd_capture;
    logic       w_rd_commit;
    logic [15:0] w_addr_next;
    logic       w_in_window;
    logic [2:0] w_offset;
    logic       w_data_wr;
    logic       w_hold;
    logic [7:0] w_lsr;
    logic [7:0] w_rd_value;
    logic       w_lsr_clr;

    logic [7:0] w_rx_head;
    logic       w_rx_empty;
    logic       w_rx_full;
    logic       w_rx_pop;
    logic       w_rx_ovr_set;
    logic       w_tx_empty;
    logic       w_tx_full;
    logic       w_tx_pop;
    logic       w_tx_room;

    assign lpc_data = r_lad_oe ? r_lad_out : 4'bzzzz;

    assign w_addr_next = {r_addr, lpc_data};
    assign w_in_window = (w_addr_next[15:3] == BASE_ADDR[15:3]);
    assign w_offset    = r_addr[2:0];
    assign w_data_wr   = r_is_write && (w_offset == c_REG_DATA);

    assign w_tx_pop    = tx_data_valid && tx_ready;
    assign w_tx_room   = !w_tx_full || w_tx_pop;
    assign w_rx_pop    = w_rd_commit && r_rd_pop;
    assign w_rx_ovr_set = rx_data_valid && w_rx_full && !w_rx_pop;
    assign w_lsr_clr   = w_rd_commit && (w_offset == c_REG_LSR);
    assign tx_data_valid = !w_tx_empty;

`ifdef LPC_UART_LONG_WAIT_EN
    assign w_hold = w_data_wr && !w_tx_room;
`else
    assign w_hold = 1'b0;
`endif

    always_comb begin
        w_lsr                 = 8'h00;
        w_lsr[c_LSR_RX_AVAIL] = !w_rx_empty;
        w_lsr[c_LSR_RX_OVR]   = r_rx_overrun;
        w_lsr[c_LSR_TX_OVF]   = r_tx_overflow;
        w_lsr[c_LSR_TX_NFULL] = !w_tx_full;
        w_lsr[c_LSR_TX_IDLE]  = w_tx_empty && !tx_busy;
    end

    always_comb begin
        case (w_offset)
            c_REG_DATA: w_rd_value = w_rx_empty ? 8'hFF : w_rx_head;
            c_REG_LSR:  w_rd_value = w_lsr;
            c_REG_SCR:  w_rd_value = r_scratch;
            default:    w_rd_value = 8'h00;
        endcase
    end

    // Bus outputs are computed one cycle ahead and registered, so LAD is
    // only ever driven from flops; a low LFRAME# leaves them at defaults.
    always_comb begin
        w_state_nx   = r_state;
        w_lad_oe_nx  = 1'b0;
        w_lad_out_nx = c_SYNC_READY;
        w_wait_nx    = 1'b0;
        w_tx_push    = 1'b0;
        w_tx_ovf_set = 1'b0;
        w_scr_we     = 1'b0;
        w_rd_capture = 1'b0;
        w_rd_commit  = 1'b0;
        if (!lpc_frame) begin
            w_state_nx = (lpc_data == c_START) ? ST_CTDIR : ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:     w_state_nx = ST_IDLE;
                ST_CTDIR:    w_state_nx = (lpc_data == c_CTDIR_IO_RD ||
                                           lpc_data == c_CTDIR_IO_WR) ? ST_ADDR3 : ST_IDLE;
                ST_ADDR3:    w_state_nx = ST_ADDR2;
                ST_ADDR2:    w_state_nx = ST_ADDR1;
                ST_ADDR1:    w_state_nx = ST_ADDR0;
                ST_ADDR0: begin
                    if (!w_in_window)   w_state_nx = ST_IDLE;
                    else if (r_is_write) w_state_nx = ST_WDATA_LO;
                    else                w_state_nx = ST_HTAR0;
                end
                ST_WDATA_LO: w_state_nx = ST_WDATA_HI;
                ST_WDATA_HI: w_state_nx = ST_HTAR0;
                ST_HTAR0:    w_state_nx = ST_HTAR1;
                ST_HTAR1: begin
                    w_state_nx   = ST_SYNC;
                    w_lad_oe_nx  = 1'b1;
                    w_wait_nx    = w_hold;
                    w_lad_out_nx = w_hold ? c_SYNC_LWAIT : c_SYNC_READY;
                end
                ST_SYNC: begin
                    w_lad_oe_nx = 1'b1;
                    if (r_wait) begin
                        w_state_nx   = ST_SYNC;
                        w_wait_nx    = w_hold;
                        w_lad_out_nx = w_hold ? c_SYNC_LWAIT : c_SYNC_READY;
                    end else if (r_is_write) begin
                        w_state_nx   = ST_PTAR0;
                        w_lad_out_nx = c_TAR_DRIVE;
                        w_tx_push    = w_data_wr && w_tx_room;
                        w_tx_ovf_set = w_data_wr && !w_tx_room;
                        w_scr_we     = (w_offset == c_REG_SCR);
                    end else begin
                        w_state_nx   = ST_RDATA_LO;
                        w_lad_out_nx = w_rd_value[3:0];
                        w_rd_capture = 1'b1;
                    end
                end
                ST_RDATA_LO: begin
                    w_state_nx   = ST_RDATA_HI;
                    w_lad_oe_nx  = 1'b1;
                    w_lad_out_nx = r_rdata[7:4];
                end
                ST_RDATA_HI: begin
                    w_state_nx   = ST_PTAR0;
                    w_lad_oe_nx  = 1'b1;
                    w_lad_out_nx = c_TAR_DRIVE;
                    w_rd_commit  = 1'b1;
                end
                ST_PTAR0:    w_state_nx = ST_PTAR1;
                ST_PTAR1:    w_state_nx = ST_IDLE;
                default:     w_state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge lpc_clk or negedge lpc_rst) begin
        if (!lpc_rst) begin
            r_state       <= ST_IDLE;
            r_is_write    <= 1'b0;
            r_addr        <= 12'h000;
            r_wdata       <= 8'h00;
            r_rdata       <= 8'h00;
            r_rd_pop      <= 1'b0;
            r_lad_oe      <= 1'b0;
            r_lad_out     <= 4'h0;
            r_wait        <= 1'b0;
            r_scratch     <= 8'h00;
            r_rx_overrun  <= 1'b0;
            r_tx_overflow <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_lad_oe  <= w_lad_oe_nx;
            r_lad_out <= w_lad_out_nx;
            r_wait    <= w_wait_nx;
            if (r_state == ST_CTDIR) r_is_write <= (lpc_data == c_CTDIR_IO_WR);
            if (r_state inside {ST_ADDR3, ST_ADDR2, ST_ADDR1, ST_ADDR0})
                r_addr <= w_addr_next[11:0];
            if (r_state == ST_WDATA_LO) r_wdata[3:0] <= lpc_data;
            if (r_state == ST_WDATA_HI) r_wdata[7:4] <= lpc_data;
            if (w_rd_capture) begin
                r_rdata  <= w_rd_value;
                r_rd_pop <= (w_offset == c_REG_DATA) && !w_rx_empty;
            end
            if (w_scr_we) r_scratch <= r_wdata;
            // Only flags actually reported by this LSR read are cleared
            r_rx_overrun  <= (r_rx_overrun && !(w_lsr_clr && r_rdata[c_LSR_RX_OVR])) ||
                             w_rx_ovr_set;
            r_tx_overflow <= (r_tx_overflow && !(w_lsr_clr && r_rdata[c_LSR_TX_OVF])) ||
                             w_tx_ovf_set;
        end
    end

    lpc_uart_fifo #(
        .WIDTH (8),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .i_clk       (lpc_clk),
        .i_rst_n     (lpc_rst),
        .i_push      (rx_data_valid),
        .i_push_data (rx_data),
        .i_pop       (w_rx_pop),
        .o_head      (w_rx_head),
        .o_empty     (w_rx_empty),
        .o_full      (w_rx_full)
    );

    lpc_uart_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .i_clk       (lpc_clk),
        .i_rst_n     (lpc_rst),
        .i_push      (w_tx_push),
        .i_push_data (r_wdata),
        .i_pop       (w_tx_pop),
        .o_head      (tx_data),
        .o_empty     (w_tx_empty),
        .o_full      (w_tx_full)
    );

endmodule

`default_nettype wire
